// File: rtl/led_blink_timebase.sv
// Blink-pattern timebase for the status LEDs: one prescaler chain (1 ms -> phase slot -> 32-slot frame)
// drives every pattern enable, so all LED patterns stay phase-aligned and can be realigned together.
module led_blink_timebase #(
    parameter int MS_DIV   = 25000,
    parameter int PHASE_MS = 125,
    parameter int SLOW_MS  = 700
) (
    input  logic SYSCLK,
    input  logic RESET_N,
    input  logic BLINK_RESTART,
    output logic TICK_1MS,
    output logic TICK_125MS,
    output logic CLK_1HZ,
    output logic CLK_2HZ,
    output logic CLK_4HZ,
    output logic CLK_4HZ_500MS,
    output logic CLK_4HZ_3500MS,
    output logic CLK_07S
);

    localparam int              MS_W      = $clog2(MS_DIV);
    localparam logic [MS_W-1:0] MS_LAST   = MS_W'(MS_DIV - 1);
    localparam logic [9:0]      SLOT_LAST = 10'(PHASE_MS - 1);
    localparam logic [9:0]      SLOW_LAST = 10'(SLOW_MS - 1);

    // Slot and slow counters are 10 bits wide, so their terminal counts must fit in 10 bits.
    generate
        if (MS_DIV < 2 || PHASE_MS < 2 || SLOW_MS < 2 || PHASE_MS > 1024 || SLOW_MS > 1024) begin : g_bad_param
            $error("led_blink_timebase: MS_DIV, PHASE_MS and SLOW_MS must be >= 2 (and PHASE_MS, SLOW_MS <= 1024)");
        end
    endgenerate

    logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [9:0]      slot_cnt_q, slot_cnt_d;
    logic [4:0]      ph_q, ph_d;
    logic [9:0]      slow_cnt_q, slow_cnt_d;
    logic            slow_lvl_q, slow_lvl_d;

    logic tick_1ms_q, tick_1ms_d;
    logic tick_slot_q, tick_slot_d;
    logic clk_1hz_q, clk_1hz_d;
    logic clk_2hz_q, clk_2hz_d;
    logic clk_4hz_q, clk_4hz_d;
    logic clk_4hz_500ms_q, clk_4hz_500ms_d;
    logic clk_4hz_3500ms_q, clk_4hz_3500ms_d;
    logic clk_07s_q, clk_07s_d;

    logic tick_1ms;
    logic tick_slot;
    logic slow_wrap;

    always_comb begin
        tick_1ms  = (ms_cnt_q == MS_LAST);
        tick_slot = tick_1ms && (slot_cnt_q == SLOT_LAST);
        slow_wrap = tick_1ms && (slow_cnt_q == SLOW_LAST);

        ms_cnt_d   = ms_cnt_q;
        slot_cnt_d = slot_cnt_q;
        ph_d       = ph_q;
        slow_cnt_d = slow_cnt_q;
        slow_lvl_d = slow_lvl_q;

        if (BLINK_RESTART) begin
            ms_cnt_d   = '0;
            slot_cnt_d = '0;
            ph_d       = '0;
            slow_cnt_d = '0;
            slow_lvl_d = 1'b1;
        end else begin
            ms_cnt_d = tick_1ms ? '0 : ms_cnt_q + 1'b1;
            if (tick_1ms) begin
                slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + 10'd1;
                slow_cnt_d = slow_wrap ? '0 : slow_cnt_q + 10'd1;
            end
            if (tick_slot) begin
                ph_d = ph_q + 5'd1;
            end
            if (slow_wrap) begin
                slow_lvl_d = ~slow_lvl_q;
            end
        end

        // Patterns decode the pre-update counter state; a restart only suppresses the tick strobes.
        clk_4hz_d        = ~ph_q[0];
        clk_2hz_d        = ~ph_q[1];
        clk_1hz_d        = ~ph_q[2];
        clk_4hz_500ms_d  = ~ph_q[0] & ~ph_q[2];
        clk_4hz_3500ms_d = ~ph_q[0] & (ph_q[4:2] == 3'd0);
        clk_07s_d        = slow_lvl_q;
        tick_1ms_d       = tick_1ms & ~BLINK_RESTART;
        tick_slot_d      = tick_slot & ~BLINK_RESTART;
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ms_cnt_q         <= '0;
            slot_cnt_q       <= '0;
            ph_q             <= '0;
            slow_cnt_q       <= '0;
            slow_lvl_q       <= 1'b1;
            tick_1ms_q       <= 1'b0;
            tick_slot_q      <= 1'b0;
            clk_1hz_q        <= 1'b0;
            clk_2hz_q        <= 1'b0;
            clk_4hz_q        <= 1'b0;
            clk_4hz_500ms_q  <= 1'b0;
            clk_4hz_3500ms_q <= 1'b0;
            clk_07s_q        <= 1'b0;
        end else begin
            ms_cnt_q         <= ms_cnt_d;
            slot_cnt_q       <= slot_cnt_d;
            ph_q             <= ph_d;
            slow_cnt_q       <= slow_cnt_d;
            slow_lvl_q       <= slow_lvl_d;
            tick_1ms_q       <= tick_1ms_d;
            tick_slot_q      <= tick_slot_d;
            clk_1hz_q        <= clk_1hz_d;
            clk_2hz_q        <= clk_2hz_d;
            clk_4hz_q        <= clk_4hz_d;
            clk_4hz_500ms_q  <= clk_4hz_500ms_d;
            clk_4hz_3500ms_q <= clk_4hz_3500ms_d;
            clk_07s_q        <= clk_07s_d;
        end
    end

    assign TICK_1MS       = tick_1ms_q;
    assign TICK_125MS     = tick_slot_q;
    assign CLK_1HZ        = clk_1hz_q;
    assign CLK_2HZ        = clk_2hz_q;
    assign CLK_4HZ        = clk_4hz_q;
    assign CLK_4HZ_500MS  = clk_4hz_500ms_q;
    assign CLK_4HZ_3500MS = clk_4hz_3500ms_q;
    assign CLK_07S        = clk_07s_q;

endmodule

// File: tb/tb_led_blink_timebase.sv
// Bench for led_blink_timebase: an elapsed-time model predicts every output each cycle, plus literal
// checks of release timing, pattern toggle counts, restart behaviour and async reset.
module tb_led_blink_timebase;

    localparam int MS_DIV   = 4;
    localparam int PHASE_MS = 125;
    localparam int SLOW_MS  = 700;

    logic SYSCLK = 1'b0;
    logic RESET_N;
    logic BLINK_RESTART;
    logic TICK_1MS, TICK_125MS, CLK_1HZ, CLK_2HZ, CLK_4HZ;
    logic CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S;

    int n_checks = 0;
    int n_fail   = 0;
    int n_printed = 0;

    led_blink_timebase #(
        .MS_DIV  (MS_DIV),
        .PHASE_MS(PHASE_MS),
        .SLOW_MS (SLOW_MS)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RESET_N       (RESET_N),
        .BLINK_RESTART (BLINK_RESTART),
        .TICK_1MS      (TICK_1MS),
        .TICK_125MS    (TICK_125MS),
        .CLK_1HZ       (CLK_1HZ),
        .CLK_2HZ       (CLK_2HZ),
        .CLK_4HZ       (CLK_4HZ),
        .CLK_4HZ_500MS (CLK_4HZ_500MS),
        .CLK_4HZ_3500MS(CLK_4HZ_3500MS),
        .CLK_07S       (CLK_07S)
    );

    always #5 SYSCLK = ~SYSCLK;

    // {TICK_1MS, TICK_125MS, CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S}
    logic [7:0] dut_vec;
    assign dut_vec = {TICK_1MS, TICK_125MS, CLK_1HZ, CLK_2HZ, CLK_4HZ,
                      CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S};

    // Outputs for a timebase that has been running t cycles since its last alignment point.
    function automatic logic [7:0] model_out(int unsigned t);
        int unsigned ms_total;
        int unsigned ph;
        logic t1, ts, slow;
        ms_total = t / MS_DIV;
        t1       = ((t % MS_DIV) == MS_DIV - 1);
        ts       = t1 && ((ms_total % PHASE_MS) == PHASE_MS - 1);
        ph       = (ms_total / PHASE_MS) % 32;
        slow     = ((ms_total / SLOW_MS) % 2) == 0;
        return {t1, ts, (ph / 4) % 2 == 0, (ph / 2) % 2 == 0, ph % 2 == 0,
                (ph % 8 == 0) || (ph % 8 == 2), (ph == 0) || (ph == 2), slow};
    endfunction

    int unsigned tm;
    logic [7:0]  exp_q;

    always @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            exp_q <= 8'h00;
            tm    <= 0;
        end else begin
            exp_q <= model_out(tm) & (BLINK_RESTART ? 8'h3F : 8'hFF);
            tm    <= BLINK_RESTART ? 0 : tm + 1;
        end
    end

    always @(negedge SYSCLK) begin
        n_checks++;
        if (dut_vec !== exp_q) begin
            n_fail++;
            if (n_printed < 20) begin
                n_printed++;
                $display("FAIL model_cycle time=%0t t=%0d got=%b expected=%b", $time, tm, dut_vec, exp_q);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, actual, expected);
        end else begin
            $display("check %s = %0d ok", name, actual);
        end
    endtask

    initial begin
        int first_tick, n_tick1, n_tick125;
        int tr_4hz, tr_2hz, tr_1hz, tr_07s, hi_500, hi_3500;
        logic p_4hz, p_2hz, p_1hz, p_07s;
        int hold_bad;
        int seg_len;

        RESET_N       = 1'b0;
        BLINK_RESTART = 1'b0;
        repeat (10) @(negedge SYSCLK);
        check("reset_outputs", int'(dut_vec), 0);
        RESET_N = 1'b1;

        first_tick = 0; n_tick1 = 0; n_tick125 = 0;
        tr_4hz = 0; tr_2hz = 0; tr_1hz = 0; tr_07s = 0; hi_500 = 0; hi_3500 = 0;
        p_4hz = 1'b0; p_2hz = 1'b0; p_1hz = 1'b0; p_07s = 1'b0;
        for (int k = 1; k <= 16000; k++) begin
            @(negedge SYSCLK);
            if (k == 1) check("release_pattern", int'(dut_vec), 8'h3F);
            if (TICK_1MS && first_tick == 0) first_tick = k;
            if (TICK_1MS) n_tick1++;
            if (TICK_125MS) n_tick125++;
            if (CLK_4HZ != p_4hz) tr_4hz++;
            if (CLK_2HZ != p_2hz) tr_2hz++;
            if (CLK_1HZ != p_1hz) tr_1hz++;
            if (k <= 11200 && CLK_07S != p_07s) tr_07s++;
            if (CLK_4HZ_500MS) hi_500++;
            if (CLK_4HZ_3500MS) hi_3500++;
            p_4hz = CLK_4HZ; p_2hz = CLK_2HZ; p_1hz = CLK_1HZ; p_07s = CLK_07S;
        end
        check("first_tick_1ms_cycle", first_tick, 4);
        check("tick_1ms_count", n_tick1, 4000);
        check("tick_125ms_count", n_tick125, 32);
        check("clk_4hz_edges", tr_4hz, 32);
        check("clk_2hz_edges", tr_2hz, 16);
        check("clk_1hz_edges", tr_1hz, 8);
        check("clk_07s_edges", tr_07s, 4);
        check("clk_4hz_500ms_high", hi_500, 4000);
        check("clk_4hz_3500ms_high", hi_3500, 1000);

        // Advance to the last cycle of slot 13, where a 1 ms and a slot wrap coincide.
        repeat (6999) @(negedge SYSCLK);
        BLINK_RESTART = 1'b1;
        @(negedge SYSCLK);
        check("restart_ticks_suppressed", int'({TICK_1MS, TICK_125MS}), 0);
        check("restart_slot13_4hz_1hz", int'({CLK_4HZ, CLK_1HZ}), 0);
        BLINK_RESTART = 1'b0;
        @(negedge SYSCLK);
        check("restart_phase0", int'(dut_vec), 8'h3F);

        BLINK_RESTART = 1'b1;
        hold_bad = 0;
        repeat (3000) begin
            @(negedge SYSCLK);
            if (dut_vec !== 8'h3F) hold_bad++;
        end
        check("hold_restart_bad_cycles", hold_bad, 0);
        BLINK_RESTART = 1'b0;

        for (int s = 0; s < 4; s++) begin
            seg_len = int'($urandom_range(1000, 6000));
            for (int i = 0; i < seg_len; i++) begin
                @(negedge SYSCLK);
                BLINK_RESTART = ($urandom_range(0, 399) == 0);
            end
            @(negedge SYSCLK);
            BLINK_RESTART = 1'b0;
            #2 RESET_N = 1'b0;
            #1 check("async_reset_outputs", int'(dut_vec), 0);
            repeat (3) @(negedge SYSCLK);
            RESET_N = 1'b1;
            repeat (int'($urandom_range(1, 600))) @(negedge SYSCLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
